// File: rtl/key_debounce_if.sv
// Handshake bundle for key_debounce: tick/raw key in, conditioned key events out.
interface key_debounce_if;
    logic i_tick;
    logic i_key_n;
    logic o_key_down;
    logic o_press;
    logic o_release;
    logic o_long_press;
    logic o_repeat_p;
    logic o_held;

    modport master (
        output i_tick, i_key_n,
        input  o_key_down, o_press, o_release,
        input  o_long_press, o_repeat_p, o_held
    );

    modport slave (
        input  i_tick, i_key_n,
        output o_key_down, o_press, o_release,
        output o_long_press, o_repeat_p, o_held
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF sync, tick-based integrating debounce,
// press/release pulses, long-press detection and auto-repeat.
module key_debounce #(
    parameter logic [15:0] CNT_MAX  = 16'd20,
    parameter logic [15:0] LONG_MAX = 16'd1000,
    parameter logic [15:0] RPT_MAX  = 16'd200
) (
    input logic         clk,
    input logic         RST,
    key_debounce_if.slave bus
);

    localparam logic [15:0] L_CNT_TOP  = CNT_MAX - 16'd1;
    localparam logic [15:0] L_LONG_TOP = LONG_MAX - 16'd1;
    localparam logic [15:0] L_RPT_TOP  = RPT_MAX - 16'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESSED,
        S_HELD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_sync1;
    logic        r_sync2;
    logic [15:0] r_dcnt;
    logic        r_key_down;
    logic        r_press;
    logic        r_release;

    logic [15:0] r_hcnt;
    logic [15:0] r_rcnt;
    logic        r_long;
    logic        r_rpt;
    logic        r_held;

    logic [15:0] w_hcnt_nxt;
    logic [15:0] w_rcnt_nxt;
    logic        w_long_nxt;
    logic        w_rpt_nxt;
    logic        w_held_nxt;

    logic        w_ks;
    logic        w_diff;
    logic        w_acc;
    logic        w_acc_press;
    logic        w_acc_rel;
    logic        w_hold_top;
    logic        w_rpt_top;

    assign w_ks        = ~r_sync2;
    assign w_diff      = w_ks != r_key_down;
    assign w_acc       = bus.i_tick & w_diff & (r_dcnt == L_CNT_TOP);
    assign w_acc_press = w_acc & w_ks;
    assign w_acc_rel   = w_acc & ~w_ks;
    assign w_hold_top  = bus.i_tick & (r_hcnt == L_LONG_TOP);
    assign w_rpt_top   = bus.i_tick & (RPT_MAX != 16'd0)
                       & (r_rcnt == L_RPT_TOP);

    // Any sample matching the accepted level wipes debounce progress.
    always_ff @(posedge clk) begin
        if (RST) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_dcnt     <= 16'd0;
            r_key_down <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
        end else begin
            r_sync1   <= bus.i_key_n;
            r_sync2   <= r_sync1;
            r_press   <= w_acc_press;
            r_release <= w_acc_rel;
            if (w_acc) begin
                r_key_down <= w_ks;
                r_dcnt     <= 16'd0;
            end else if (!w_diff) begin
                r_dcnt <= 16'd0;
            end else if (bus.i_tick) begin
                r_dcnt <= r_dcnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_hcnt  <= 16'd0;
            r_rcnt  <= 16'd0;
            r_long  <= 1'b0;
            r_rpt   <= 1'b0;
            r_held  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_long  <= w_long_nxt;
            r_rpt   <= w_rpt_nxt;
            r_held  <= w_held_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc_press) w_state_nxt = S_PRESSED;
            end
            S_PRESSED: begin
                if (w_acc_rel)       w_state_nxt = S_IDLE;
                else if (w_hold_top) w_state_nxt = S_HELD;
            end
            S_HELD: begin
                if (w_acc_rel) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Release wins over long_press/repeat_p on the same tick.
    always_comb begin
        w_hcnt_nxt = r_hcnt;
        w_rcnt_nxt = r_rcnt;
        w_long_nxt = 1'b0;
        w_rpt_nxt  = 1'b0;
        w_held_nxt = r_held;
        unique case (r_state)
            S_IDLE: begin
                w_hcnt_nxt = 16'd0;
                w_rcnt_nxt = 16'd0;
                w_held_nxt = 1'b0;
            end
            S_PRESSED: begin
                if (w_acc_rel) begin
                    w_hcnt_nxt = 16'd0;
                    w_rcnt_nxt = 16'd0;
                    w_held_nxt = 1'b0;
                end else if (w_hold_top) begin
                    w_long_nxt = 1'b1;
                    w_held_nxt = 1'b1;
                    w_rcnt_nxt = 16'd0;
                end else if (bus.i_tick) begin
                    w_hcnt_nxt = r_hcnt + 16'd1;
                end
            end
            S_HELD: begin
                if (w_acc_rel) begin
                    w_hcnt_nxt = 16'd0;
                    w_rcnt_nxt = 16'd0;
                    w_held_nxt = 1'b0;
                end else if (w_rpt_top) begin
                    w_rpt_nxt  = 1'b1;
                    w_rcnt_nxt = 16'd0;
                end else if (bus.i_tick && RPT_MAX != 16'd0) begin
                    w_rcnt_nxt = r_rcnt + 16'd1;
                end
            end
            default: begin
                w_hcnt_nxt = 16'd0;
                w_rcnt_nxt = 16'd0;
                w_held_nxt = 1'b0;
            end
        endcase
    end

    assign bus.o_key_down   = r_key_down;
    assign bus.o_press      = r_press;
    assign bus.o_release    = r_release;
    assign bus.o_long_press = r_long;
    assign bus.o_repeat_p   = r_rpt;
    assign bus.o_held       = r_held;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: two instances (repeat on / repeat off) driven
// together and compared every cycle against an event-level model.
module tb_key_debounce;

    localparam logic [15:0] P_CNT  = 16'd4;
    localparam logic [15:0] P_LONG = 16'd10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic key_n = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit tick_all = 1'b0;

    int c_press[2];
    int c_rel[2];
    int c_long[2];
    int c_rpt[2];

    // model state, index 0 = RPT_MAX 3, index 1 = RPT_MAX 0
    int m_rptmax[2] = '{3, 0};
    bit m_s1[2];
    bit m_s2[2];
    bit m_lvl[2];
    int m_run[2];
    int m_hold[2];
    bit m_pr[2];
    bit m_rl[2];
    bit m_lp[2];
    bit m_rp[2];
    bit m_held[2];

    key_debounce_if bus_a ();
    key_debounce_if bus_b ();

    assign bus_a.i_tick  = tick;
    assign bus_a.i_key_n = key_n;
    assign bus_b.i_tick  = tick;
    assign bus_b.i_key_n = key_n;

    key_debounce #(
        .CNT_MAX (P_CNT),
        .LONG_MAX(P_LONG),
        .RPT_MAX (16'd3)
    ) dut_a (
        .clk(clk),
        .RST(rst),
        .bus(bus_a)
    );

    key_debounce #(
        .CNT_MAX (P_CNT),
        .LONG_MAX(P_LONG),
        .RPT_MAX (16'd0)
    ) dut_b (
        .clk(clk),
        .RST(rst),
        .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Rules: accept after CNT consecutive differing ticks; count ticks
    // after the press; long at LONG, repeat every RPT ticks beyond it.
    task automatic model_clk(input bit t, input bit kn, input bit r);
        bit ks;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_s1[i] = 1'b1; m_s2[i] = 1'b1;
                m_lvl[i] = 1'b0; m_run[i] = 0; m_hold[i] = 0;
                m_pr[i] = 1'b0; m_rl[i] = 1'b0;
                m_lp[i] = 1'b0; m_rp[i] = 1'b0; m_held[i] = 1'b0;
            end else begin
                ks = ~m_s2[i];
                m_pr[i] = 1'b0; m_rl[i] = 1'b0;
                m_lp[i] = 1'b0; m_rp[i] = 1'b0;
                if (ks == m_lvl[i]) begin
                    m_run[i] = 0;
                end else if (t) begin
                    m_run[i]++;
                    if (m_run[i] == int'(P_CNT)) begin
                        m_lvl[i] = ks;
                        m_run[i] = 0;
                        m_pr[i] = ks;
                        m_rl[i] = ~ks;
                    end
                end
                if (m_rl[i]) begin
                    m_hold[i] = 0;
                    m_held[i] = 1'b0;
                end else if (m_pr[i]) begin
                    m_hold[i] = 0;
                end else if (m_lvl[i] && t) begin
                    m_hold[i]++;
                    if (m_hold[i] == int'(P_LONG)) begin
                        m_lp[i] = 1'b1;
                        m_held[i] = 1'b1;
                    end else if (m_hold[i] > int'(P_LONG) && m_rptmax[i] != 0
                                 && (m_hold[i] - int'(P_LONG)) % m_rptmax[i] == 0) begin
                        m_rp[i] = 1'b1;
                    end
                end
                m_s2[i] = m_s1[i];
                m_s1[i] = kn;
            end
        end
    endtask

    task automatic check_all();
        chk("a.key_down", bus_a.o_key_down, m_lvl[0]);
        chk("a.press", bus_a.o_press, m_pr[0]);
        chk("a.release", bus_a.o_release, m_rl[0]);
        chk("a.long_press", bus_a.o_long_press, m_lp[0]);
        chk("a.repeat_p", bus_a.o_repeat_p, m_rp[0]);
        chk("a.held", bus_a.o_held, m_held[0]);
        chk("b.key_down", bus_b.o_key_down, m_lvl[1]);
        chk("b.press", bus_b.o_press, m_pr[1]);
        chk("b.release", bus_b.o_release, m_rl[1]);
        chk("b.long_press", bus_b.o_long_press, m_lp[1]);
        chk("b.repeat_p", bus_b.o_repeat_p, m_rp[1]);
        chk("b.held", bus_b.o_held, m_held[1]);
        c_press[0] += int'(bus_a.o_press === 1'b1);
        c_rel[0]   += int'(bus_a.o_release === 1'b1);
        c_long[0]  += int'(bus_a.o_long_press === 1'b1);
        c_rpt[0]   += int'(bus_a.o_repeat_p === 1'b1);
        c_press[1] += int'(bus_b.o_press === 1'b1);
        c_rel[1]   += int'(bus_b.o_release === 1'b1);
        c_long[1]  += int'(bus_b.o_long_press === 1'b1);
        c_rpt[1]   += int'(bus_b.o_repeat_p === 1'b1);
    endtask

    task automatic step(input bit kn, input bit r);
        @(negedge clk);
        cyc++;
        tick = tick_all ? 1'b1 : (cyc % 4 == 0);
        key_n = kn;
        rst = r;
        @(posedge clk);
        model_clk(tick, kn, r);
        #1;
        check_all();
    endtask

    task automatic run(input bit kn, input int n);
        for (int k = 0; k < n; k++) step(kn, 1'b0);
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 2; i++) begin
            c_press[i] = 0; c_rel[i] = 0; c_long[i] = 0; c_rpt[i] = 0;
        end
    endtask

    initial begin
        clr_cnt();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        chk("rst_key_down", bus_a.o_key_down, 1'b0);
        chk("rst_held", bus_a.o_held, 1'b0);

        clr_cnt();
        run(1'b0, 30);
        chk_int("first_press_cnt", c_press[0], 1);
        chk("first_key_down", bus_a.o_key_down, 1'b1);
        run(1'b1, 30);
        chk_int("first_release_cnt", c_rel[0], 1);

        clr_cnt();
        for (int k = 0; k < 10; k++) run(k[0], 6);
        run(1'b1, 30);
        chk_int("bounce_press_cnt", c_press[0], 0);
        chk_int("bounce_rel_cnt", c_rel[0], 0);

        clr_cnt();
        run(1'b0, 170);
        chk("long_held", bus_a.o_held, 1'b1);
        chk_int("long_cnt_a", c_long[0], 1);
        chk_int("long_cnt_b", c_long[1], 1);
        chk_int("rpt_cnt_b_off", c_rpt[1], 0);
        chk_int("rpt_seen_a", int'(c_rpt[0] >= 5), 1);
        run(1'b1, 40);
        chk_int("long_rel_cnt", c_rel[0], 1);
        chk("long_held_after_rel", bus_a.o_held, 1'b0);

        clr_cnt();
        run(1'b0, 36);
        run(1'b1, 30);
        run(1'b0, 36);
        run(1'b1, 30);
        chk_int("short_press_cnt", c_press[0], 2);
        chk_int("short_rel_cnt", c_rel[0], 2);
        chk_int("short_long_cnt", c_long[0], 0);

        clr_cnt();
        run(1'b0, 100);
        chk("midheld_held", bus_a.o_held, 1'b1);
        step(1'b0, 1'b1);
        chk("midheld_rst_key_down", bus_a.o_key_down, 1'b0);
        run(1'b0, 30);
        chk_int("midheld_rel_cnt", c_rel[0], 0);
        chk_int("midheld_repress_cnt", c_press[0], 2);

        for (int s = 0; s < 40; s++) begin
            tick_all = ($urandom_range(0, 4) == 0);
            run(1'($urandom_range(0, 1)), int'($urandom_range(1, 70)));
        end
        tick_all = 1'b0;
        run(1'b1, 40);
        chk("final_key_down", bus_a.o_key_down, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
